lcg_state_ctrl: RTL and testbench
=================================

// Module: lcg_state_ctrl
// PURPOSE
//  Sequential state/control stage directly downstream of the 64-bit sum generator (S = t ^ C).
//  Holds the LCG state x, drives it to the upstream multiply-add datapath, waits DP_LAT cycles,
//  captures S as the next state and presents each new value on a valid/ready output.
//  Also handles seed loading, run/stop control and a generated-value counter.
// PARAMETERS
//  WIDTH        64   state/sum width
//  MOD_BITS     64   modulus 2^MOD_BITS; captured S masked to low MOD_BITS (1..WIDTH)
//  DP_LAT       2    cycles from x_out change until S_in is valid (>=1)
//  SEED_DEFAULT 0    state value after reset
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  seed_load  in   1      load seed into state (priority over all other inputs)
//  seed       in   WIDTH  seed value
//  run        in   1      level: keep generating while high
//  S_in       in   WIDTH  sum from sum generator = next-state candidate
//  x_out      out  WIDTH  current state to multiply-add datapath
//  rnd_data   out  WIDTH  generated value
//  rnd_valid  out  1      rnd_data valid
//  rnd_ready  in   1      consumer accepts rnd_data
//  busy       out  1      FSM not in IDLE
//  gen_count  out  32     number of accepted outputs, wraps
// BEHAVIOUR
//  Reset: x_out=SEED_DEFAULT&mask, rnd_data=0, rnd_valid=0, busy=0, gen_count=0, FSM=IDLE.
//  FSM states: IDLE, WAIT, HOLD.
//   IDLE: run=1 -> WAIT; lat_cnt loaded with DP_LAT-1.
//   WAIT: lat_cnt decrements each cycle; at 0: x_out<=S_in&mask, rnd_data<=S_in&mask,
//         rnd_valid<=1, -> HOLD. run dropping in WAIT does not abort; the value is still delivered.
//   HOLD: rnd_valid=1, rnd_data stable. rnd_valid&rnd_ready -> gen_count+1;
//         next: run ? WAIT (lat reloaded) : IDLE. No ready -> stay, hold data.
//  Latency: first rnd_valid DP_LAT+1 cycles after run sampled high in IDLE.
//   Max throughput: one value every DP_LAT+1 cycles with rnd_ready tied high.
//  seed_load (any state): next cycle x_out=seed&mask, rnd_valid=0, FSM=IDLE, lat_cnt cleared.
//   Pending unaccepted rnd_data is discarded; gen_count unchanged. Simultaneous run: run honoured
//   the cycle after the load (IDLE->WAIT), so the new seed settles through the datapath first.
//  seed_load with rnd_valid&rnd_ready in the same cycle: the handshake completes
//   (gen_count+1), then the load applies.
//  mask = (MOD_BITS==WIDTH) ? all ones : (1<<MOD_BITS)-1. Bits above MOD_BITS are always 0.
//  gen_count wraps 0xFFFF_FFFF -> 0. No other saturation.
//  rst_n low mid-operation: all state returns to reset values immediately (async);
//   no output held across reset.
//  busy = (FSM != IDLE), combinational from the state register.
//  Only x_out feeds upstream; S_in is sampled only in the WAIT terminal cycle.
// STRUCTURE
//  mdclcg_pkg: WIDTH default, state enum {IDLE,WAIT,HOLD}, mask function mod_mask(MOD_BITS).
//  One sub-module: lcg_lat_timer (load/decrement/zero-flag down-counter, width $clog2(DP_LAT+1)).
//  Datapath (multiplier, carry/sum generation) stays outside; bench supplies a model of it.
// TESTING (upstream model: S = x*6364136223846793005 + 1442695040888963407, delayed DP_LAT)
//  1 reset, seed_load seed=0, run=1, ready=1 -> first rnd_data=0x14057B7EF767814F,
//    rnd_valid rising DP_LAT+1 cycles after run; the next values match the model.
//  2 MOD_BITS=32, seed=0 -> rnd_data=0x00000000F767814F; upper 32 bits stay 0 on all outputs.
//  3 ready held low 10 cycles in HOLD -> rnd_data/rnd_valid stable, x_out stable,
//    gen_count unchanged; ready high -> count+1, WAIT re-entered.
//  4 seed_load=1 seed=0x5 during HOLD -> rnd_valid=0 next cycle, x_out=0x5, FSM IDLE;
//    with run high, next output = model(0x5).
//  5 run dropped mid-WAIT -> the value is still delivered; after the handshake FSM=IDLE, busy=0.
//  6 force gen_count=0xFFFFFFFF, one handshake -> 0; assert rst_n low in WAIT ->
//    all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/mdclcg_pkg.sv
// Shared types and helpers for the LCG state/control stage.
`timescale 1ns/1ps
package mdclcg_pkg;

  localparam int unsigned WIDTH_DEFAULT = 64;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned MASK_MAX_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Modulus mask 2^mod_bits - 1, saturating to all ones at full width.
  function automatic logic [MASK_MAX_W-1:0] mod_mask(input int unsigned mod_bits);
    if (mod_bits >= MASK_MAX_W) return '1;
    return (MASK_MAX_W'(1) << mod_bits) - MASK_MAX_W'(1);
  endfunction

endpackage

// File: rtl/lcg_lat_timer.sv
// Datapath latency down-counter.
//  clk, rst_n : clock, async active-low reset
//  clear_i    : force count to zero (highest priority)
//  load_i     : load DP_LAT-1
//  dec_i      : decrement, stops at zero
//  zero_o     : registered count==0 flag
`timescale 1ns/1ps
module lcg_lat_timer #(
  parameter int unsigned DP_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned   CW       = $clog2(DP_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DP_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q;

  // Next count: clear > load > decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (load_i)                cnt_d = LOAD_VAL;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/lcg_state_ctrl.sv
// LCG state/control stage: holds state x, waits DP_LAT cycles for the
// upstream multiply-add result S_in, captures it as the next state and
// offers it on a valid/ready output.
//  clk, rst_n       : clock, async active-low reset
//  seed_load, seed  : load seed into state (overrides everything else)
//  run              : keep generating while high
//  S_in             : next-state candidate from the sum generator
//  x_out            : current state to the datapath
//  rnd_data/valid   : generated value, held until rnd_ready
//  busy             : FSM not idle
//  gen_count        : accepted outputs, wrapping
`timescale 1ns/1ps
module lcg_state_ctrl
  import mdclcg_pkg::*;
#(
  parameter int unsigned      WIDTH        = WIDTH_DEFAULT,
  parameter int unsigned      MOD_BITS     = 64,
  parameter int unsigned      DP_LAT       = 2,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             run,
  input  logic [WIDTH-1:0] S_in,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy,
  output logic [CNT_W-1:0] gen_count
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(mod_mask(MOD_BITS));

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   gen_count_q, gen_count_d;
  logic               lat_load, lat_dec, lat_clear, lat_zero;

  lcg_lat_timer #(.DP_LAT(DP_LAT)) u_lat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (lat_clear),
    .load_i  (lat_load),
    .dec_i   (lat_dec),
    .zero_o  (lat_zero)
  );

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    data_d      = data_q;
    valid_d     = valid_q;
    gen_count_d = gen_count_q;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;
    lat_clear   = 1'b0;

    // valid is only ever high in HOLD, so this is the handshake; it still
    // counts when a seed load lands in the same cycle.
    if (valid_q && rnd_ready) gen_count_d = gen_count_q + CNT_W'(1);

    if (seed_load) begin
      x_d       = seed & MASK;
      valid_d   = 1'b0;
      state_d   = IDLE;
      lat_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_d  = WAIT;
            lat_load = 1'b1;
          end
        end
        WAIT: begin
          if (lat_zero) begin
            x_d     = S_in & MASK;
            data_d  = S_in & MASK;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            lat_dec = 1'b1;
          end
        end
        HOLD: begin
          if (rnd_ready) begin
            valid_d = 1'b0;
            if (run) begin
              state_d  = WAIT;
              lat_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= SEED_DEFAULT & MASK;
      data_q      <= '0;
      valid_q     <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      gen_count_q <= gen_count_d;
    end
  end

  assign x_out     = x_q;
  assign rnd_data  = data_q;
  assign rnd_valid = valid_q;
  assign gen_count = gen_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcg_state_ctrl.sv
// Bench for lcg_state_ctrl: upstream multiply-add model, scoreboard of
// expected LCG outputs, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_lcg_state_ctrl;

  localparam int unsigned DPL = 2;
  localparam logic [63:0] MUL = 64'd6364136223846793005;
  localparam logic [63:0] INC = 64'd1442695040888963407;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M32 = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (full 64-bit modulus)
  logic        seed_load, run, rnd_ready, rnd_valid, busy;
  logic [63:0] seed, s_in, x_out, rnd_data;
  logic [31:0] gen_count;

  lcg_state_ctrl #(.WIDTH(64), .MOD_BITS(64), .DP_LAT(DPL)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .run(run),
    .S_in(s_in), .x_out(x_out), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .busy(busy), .gen_count(gen_count)
  );

  // Second instance with a 2^32 modulus
  logic        load32, run32, ready32, valid32, busy32;
  logic [63:0] seed32, s_in32, x_out32, data32;
  logic [31:0] count32;

  lcg_state_ctrl #(.WIDTH(64), .MOD_BITS(32), .DP_LAT(DPL)) dut32 (
    .clk(clk), .rst_n(rst_n), .seed_load(load32), .seed(seed32), .run(run32),
    .S_in(s_in32), .x_out(x_out32), .rnd_data(data32), .rnd_valid(valid32),
    .rnd_ready(ready32), .busy(busy32), .gen_count(count32)
  );

  function automatic logic [63:0] lcg_next(input logic [63:0] x, input logic [63:0] m);
    return (x * MUL + INC) & m;
  endfunction

  // Upstream datapath: S = f(x_out) appearing DPL cycles after x_out changes.
  logic [63:0] pipe   [DPL];
  logic [63:0] pipe32 [DPL];
  always @(posedge clk) begin
    pipe[0]   <= lcg_next(x_out, ALL);
    pipe32[0] <= lcg_next(x_out32, ALL);
    for (int i = 1; i < DPL; i++) begin
      pipe[i]   <= pipe[i-1];
      pipe32[i] <= pipe32[i-1];
    end
  end
  assign s_in   = pipe[DPL-1];
  assign s_in32 = pipe32[DPL-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard
  logic [63:0] exp_q[$];
  logic [63:0] exp_val;
  logic [31:0] exp_cnt = '0;
  int          hs_count = 0;

  task automatic push_batch(input logic [63:0] s);
    logic [63:0] x;
    x = s;
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      x = lcg_next(x, ALL);
      exp_q.push_back(x);
    end
  endtask

  // Monitor: every handshake pops one expected value.
  always @(negedge clk) begin
    if (rst_n && rnd_valid && rnd_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=%h required=none", rnd_data);
      end else begin
        exp_val = exp_q.pop_front();
        chk("rnd_data", rnd_data, exp_val);
      end
      chk("gen_count_at_hs", 64'(gen_count), 64'(exp_cnt));
      exp_cnt = exp_cnt + 32'd1;
    end
  end

  // Drive inputs, advance one clock; a seed load replaces the expected stream.
  task automatic step(input logic r, input logic rd, input logic ld, input logic [63:0] sd);
    run = r; rnd_ready = rd; seed_load = ld; seed = sd;
    @(posedge clk); #1;
    seed_load = 1'b0;
    if (ld) push_batch(sd);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!rnd_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rnd_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=valid_low required=valid_high", nm);
    end
  endtask

  // MOD_BITS=32 instance
  bit done32 = 1'b0;
  initial begin
    logic [63:0] e32;
    int n32;
    load32 = 0; run32 = 0; ready32 = 0; seed32 = '0;
    wait (rst_n);
    @(posedge clk); #1;
    load32 = 1;
    @(posedge clk); #1;
    load32 = 0; run32 = 1; ready32 = 1;
    e32 = lcg_next(64'd0, M32);
    n32 = 0;
    for (int i = 0; i < 30; i++) begin
      chk("upper_bits_32", {x_out32[63:32], data32[63:32]}, 64'd0);
      if (valid32) begin
        if (n32 == 0) chk("first_32", data32, 64'h0000_0000_F767_814F);
        chk("seq_32", data32, e32);
        e32 = lcg_next(e32, M32);
        n32++;
      end
      @(posedge clk); #1;
    end
    chk("outputs_32", 64'(n32), 64'd9);
    done32 = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0, x0;
    logic [31:0] g0;
    int n;
    seed_load = 0; seed = '0; run = 0; rnd_ready = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x_out", x_out, 64'd0);
    chk("rst_rnd_data", rnd_data, 64'd0);
    chk("rst_rnd_valid", 64'(rnd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gen_count", 64'(gen_count), 64'd0);
    rst_n = 1'b1;

    // 1: seed 0, first value and latency, then throughput
    step(1'b0, 1'b1, 1'b1, 64'd0);
    chk("load0_busy", 64'(busy), 64'd0);
    run = 1'b1;
    n = 0;
    while (!rnd_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_latency", 64'(n), 64'(DPL + 1));
    chk("first_value", rnd_data, 64'h1405_7B7E_F767_814F);
    g0 = gen_count;
    repeat (3 * (DPL + 1)) @(posedge clk);
    #1;
    chk("throughput", 64'(gen_count), 64'(g0 + 32'd3));

    // 3: back-pressure holds everything
    rnd_ready = 1'b0;
    wait_valid("hold");
    d0 = rnd_data; x0 = x_out; g0 = gen_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {rnd_valid, rnd_data ^ d0 ^ x_out ^ x0, gen_count ^ g0},
          {1'b1, 64'd0, 32'd0});
    end
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_count", 64'(gen_count), 64'(g0 + 32'd1));
    chk("hold_release_wait", {62'd0, busy, rnd_valid}, 64'd2);

    // 4: seed load during HOLD discards the pending value
    rnd_ready = 1'b0;
    wait_valid("pre_seed");
    g0 = gen_count;
    step(1'b1, 1'b0, 1'b1, 64'h5);
    chk("seed_valid", 64'(rnd_valid), 64'd0);
    chk("seed_x_out", x_out, 64'h5);
    chk("seed_busy", 64'(busy), 64'd0);
    chk("seed_count", 64'(gen_count), 64'(g0));
    rnd_ready = 1'b1;
    wait_valid("post_seed");
    chk("post_seed_value", rnd_data, lcg_next(64'h5, ALL));

    // 5: run dropped mid-WAIT still delivers
    @(posedge clk); #1;
    chk("rerun_busy", 64'(busy), 64'd1);
    run = 1'b0;
    wait_valid("run_drop");
    @(posedge clk); #1;
    chk("run_drop_idle", {62'd0, busy, rnd_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_drop_stays_idle", 64'(busy), 64'd0);

    // 6: counter wrap, then async reset in WAIT
    run = 1'b1; rnd_ready = 1'b0;
    wait_valid("wrap");
    force dut.gen_count_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.gen_count_q;
    chk("wrap_pre", 64'(gen_count), 64'hFFFF_FFFF);
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    chk("wrap_post", 64'(gen_count), 64'd0);
    chk("wrap_in_wait", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x_out", x_out, 64'd0);
    chk("arst_rnd_data", rnd_data, 64'd0);
    chk("arst_valid_busy", {62'd0, rnd_valid, busy}, 64'd0);
    chk("arst_gen_count", 64'(gen_count), 64'd0);
    exp_cnt = '0;
    push_batch(64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized phase
    hs_count = 0;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), {$urandom, $urandom});
    end
    chk("rand_handshakes_seen", 64'(hs_count > 20), 64'd1);

    wait (done32 || !rst_n);
    chk("dut32_done", 64'(done32), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
